// File: rtl/instr_fetch.sv
// Fetch stage in front of the instruction ROM: owns the PC, registers the ROM word for decode.
// Latency: first word valid one edge after reset release; redirect target valid two edges after the pulse edge.
// Backpressure: if_valid/if_instr/if_pc hold while if_ready=0; a new word is captured only when the register is free or draining.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   fetch_en                        allow new fetches (pending word still handed off when low)
//   rom_addr / rom_data             combinational ROM lookup at the current PC
//   if_valid / if_ready             valid/ready handoff to decode
//   if_instr / if_pc                delivered word and the address it came from
//   redirect_valid / redirect_pc    one-cycle restart request from downstream
//   halted                          fetch stopped on an all-zero word
//
// Optional feature macro: FETCH_HALT_DETECT_EN enables halt-word detection.
// Without it, halted is tied to 0 and zero words are delivered normally.
module instr_fetch #(
    parameter int            AW       = 4,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          halted
);

    logic [AW-1:0] pc;
    logic          valid_q;
    logic [DW-1:0] instr_q;
    logic [AW-1:0] pc_q;
    logic          halted_q;
    logic          halt_hit;
    logic          load;

    // The instruction register can take a new word when empty or when its
    // current word leaves this cycle; if_ready only steers state, never if_valid
    // combinationally.
    assign load = fetch_en & ~halted_q & (~valid_q | if_ready);

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = (rom_data == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (load && halt_hit) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halt_hit = 1'b0;
    assign halted_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (redirect_valid) begin
            // Any word on offer this cycle is dropped; the delivered-word
            // registers keep their old contents until the next capture.
            pc      <= redirect_pc;
            valid_q <= 1'b0;
        end else if (load) begin
            if (halt_hit) begin
                // Halt word is swallowed and the PC stays on it.
                valid_q <= 1'b0;
            end else begin
                instr_q <= rom_data;
                pc_q    <= pc;
                valid_q <= 1'b1;
                pc      <= pc + AW'(1);
            end
        end else if (valid_q && if_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rom_addr = pc;
    assign if_valid = valid_q;
    assign if_instr = instr_q;
    assign if_pc    = pc_q;
    assign halted   = halted_q;

endmodule
